// File: rtl/frame_scheduler.sv
// frame_scheduler: issues start pulses to the image source, snoops the AXI4-Stream
// handshake into the encoder, checks tuser/tlast framing and enforces an
// inter-frame gap. No datapath; every output is a register.
// Optional stall watchdog: define FRAME_SCHEDULER_WATCHDOG_EN.
module frame_scheduler #(
    parameter int unsigned WIDTH              = 64,
    parameter int unsigned HEIGHT             = 64,
    parameter int unsigned GAP_CYCLES         = 16,
    parameter int unsigned FRAME_CNT_BITWIDTH = 16,
    parameter int unsigned TIMEOUT_CYCLES     = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_enable,
    input  logic [FRAME_CNT_BITWIDTH-1:0] i_num_frames,
    output logic                          o_gen_start,
    input  logic                          i_axis_tvalid,
    input  logic                          i_axis_tready,
    input  logic                          i_axis_tuser,
    input  logic                          i_axis_tlast,
    output logic                          o_busy,
    output logic                          o_frame_done,
    output logic [FRAME_CNT_BITWIDTH-1:0] o_frame_count,
    output logic                          o_done,
    output logic                          o_err_sof,
    output logic                          o_err_eol,
    output logic                          o_err_timeout
);

    localparam int unsigned COL_W = $clog2(WIDTH);
    localparam int unsigned ROW_W = $clog2(HEIGHT);
    localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StRun,
        StGap,
        StDone
    } state_e;

    state_e                          state_q, state_d;
    logic                            enable_q;
    logic [FRAME_CNT_BITWIDTH-1:0]   num_q, num_d;
    logic [FRAME_CNT_BITWIDTH-1:0]   count_q, count_d;
    logic [COL_W-1:0]                col_q, col_d;
    logic [ROW_W-1:0]                row_q, row_d;
    logic [GAP_W-1:0]                gap_q, gap_d;
    logic                            gen_start_q, gen_start_d;
    logic                            frame_done_q, frame_done_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            err_sof_q, err_sof_d;
    logic                            err_eol_q, err_eol_d;

    logic xfer;
    logic col_last;
    logic row_last;
    logic at_origin;
    logic frames_left;

`ifdef FRAME_SCHEDULER_WATCHDOG_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               err_to_q, err_to_d;
`endif

    assign xfer        = i_axis_tvalid & i_axis_tready;
    assign col_last    = (col_q == COL_LAST);
    assign row_last    = (row_q == ROW_LAST);
    assign at_origin   = (col_q == '0) && (row_q == '0);
    // count_q already includes the frame just finished; zero requests run forever.
    assign frames_left = (num_q == '0) || (count_q != num_q);

    // Next-state and next-output decode.
    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        count_d      = count_q;
        col_d        = col_q;
        row_d        = row_q;
        gap_d        = gap_q;
        gen_start_d  = 1'b0;
        frame_done_d = 1'b0;
        err_sof_d    = err_sof_q;
        err_eol_d    = err_eol_q;
`ifdef FRAME_SCHEDULER_WATCHDOG_EN
        stall_d      = stall_q;
        err_to_d     = err_to_q;
`endif

        case (state_q)
            StIdle: begin
                if (i_enable && !enable_q) begin
                    state_d     = StStart;
                    num_d       = i_num_frames;
                    count_d     = '0;
                    err_sof_d   = 1'b0;
                    err_eol_d   = 1'b0;
                    gen_start_d = 1'b1;
`ifdef FRAME_SCHEDULER_WATCHDOG_EN
                    err_to_d    = 1'b0;
`endif
                end
            end
            StStart: begin
                col_d   = '0;
                row_d   = '0;
                state_d = StRun;
`ifdef FRAME_SCHEDULER_WATCHDOG_EN
                stall_d = '0;
`endif
            end
            StRun: begin
                if (xfer) begin
                    // Position advances regardless of errors; tuser never resyncs.
                    if (i_axis_tuser != at_origin) err_sof_d = 1'b1;
                    if (i_axis_tlast != col_last) err_eol_d = 1'b1;
`ifdef FRAME_SCHEDULER_WATCHDOG_EN
                    stall_d = '0;
`endif
                    if (col_last) begin
                        col_d = '0;
                        if (row_last) begin
                            row_d        = '0;
                            count_d      = count_q + 1'b1;
                            frame_done_d = 1'b1;
                            gap_d        = '0;
                            state_d      = StGap;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
`ifdef FRAME_SCHEDULER_WATCHDOG_EN
                else if (stall_q == STALL_LAST) begin
                    err_to_d = 1'b1;
                    state_d  = StDone;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
`endif
            end
            StGap: begin
                if (gap_q == GAP_LAST) begin
                    if (i_enable && frames_left) begin
                        state_d     = StStart;
                        gen_start_d = 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StDone: begin
                if (!i_enable) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StStart) || (state_d == StRun) || (state_d == StGap);
        done_d = (state_d == StDone);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            enable_q     <= 1'b0;
            num_q        <= '0;
            count_q      <= '0;
            col_q        <= '0;
            row_q        <= '0;
            gap_q        <= '0;
            gen_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_sof_q    <= 1'b0;
            err_eol_q    <= 1'b0;
`ifdef FRAME_SCHEDULER_WATCHDOG_EN
            stall_q      <= '0;
            err_to_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            enable_q     <= i_enable;
            num_q        <= num_d;
            count_q      <= count_d;
            col_q        <= col_d;
            row_q        <= row_d;
            gap_q        <= gap_d;
            gen_start_q  <= gen_start_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_sof_q    <= err_sof_d;
            err_eol_q    <= err_eol_d;
`ifdef FRAME_SCHEDULER_WATCHDOG_EN
            stall_q      <= stall_d;
            err_to_q     <= err_to_d;
`endif
        end
    end

    assign o_gen_start   = gen_start_q;
    assign o_busy        = busy_q;
    assign o_frame_done  = frame_done_q;
    assign o_frame_count = count_q;
    assign o_done        = done_q;
    assign o_err_sof     = err_sof_q;
    assign o_err_eol     = err_eol_q;

`ifdef FRAME_SCHEDULER_WATCHDOG_EN
    assign o_err_timeout = err_to_q;
`else
    // No watchdog: RUN waits indefinitely for the stream.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign o_err_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: a table of whole-run scenarios plus
// hand-written reset-mid-run and stall sequences.
module tb_frame_scheduler;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int G   = 3;
    localparam int TO  = 20;
    localparam int PIX = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_enable = 1'b0;
    logic [15:0] i_num_frames = '0;
    logic        o_gen_start;
    logic        i_axis_tvalid = 1'b0;
    logic        i_axis_tready = 1'b0;
    logic        i_axis_tuser = 1'b0;
    logic        i_axis_tlast = 1'b0;
    logic        o_busy;
    logic        o_frame_done;
    logic [15:0] o_frame_count;
    logic        o_done;
    logic        o_err_sof;
    logic        o_err_eol;
    logic        o_err_timeout;

    frame_scheduler #(
        .WIDTH             (W),
        .HEIGHT            (H),
        .GAP_CYCLES        (G),
        .FRAME_CNT_BITWIDTH(16),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (i_enable),
        .i_num_frames (i_num_frames),
        .o_gen_start  (o_gen_start),
        .i_axis_tvalid(i_axis_tvalid),
        .i_axis_tready(i_axis_tready),
        .i_axis_tuser (i_axis_tuser),
        .i_axis_tlast (i_axis_tlast),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_frame_count(o_frame_count),
        .o_done       (o_done),
        .o_err_sof    (o_err_sof),
        .o_err_eol    (o_err_eol),
        .o_err_timeout(o_err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nf;           // i_num_frames
        bit rmode;        // 0: tready held 1, 1: tready toggles
        int inj_sof;      // beat index in frame 0 whose tuser is inverted (-1 none)
        int inj_eol;      // beat index in frame 0 whose tlast is inverted (-1 none)
        int drop;         // drop i_enable during this frame number (0 never)
        int exp_frames;
        bit exp_sof;
        bit exp_eol;
        int exp_spacing;  // first-to-second gen_start distance (0 skip)
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Source model state
    bit ready_mode, tog, src_on, src_arm, src_stall;
    int src_idx, frames_sent, inj_sof, inj_eol, drop_frame;
    int sof_inj_cyc, eol_inj_cyc;

    // Monitor state
    int gs_cnt, fd_cnt, fd_last, sof_cyc, eol_cyc, to_cyc;
    int gs_cyc[2];
    bit done_seen;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        if (o_gen_start) begin
            check("busy_in_start", int'(o_busy), 1);
            // next start follows the previous frame_done by GAP+1 cycles
            if (fd_last >= 0) check("done_to_start", cyc - fd_last, G + 1);
            if (gs_cnt < 2) gs_cyc[gs_cnt] = cyc;
            gs_cnt++;
        end
        if (o_frame_done) begin
            // last beat was accepted at the edge just before; not yet accounted
            check("beats_at_done", src_idx + int'(i_axis_tvalid && i_axis_tready), PIX);
            fd_cnt++;
            fd_last = cyc;
        end
        if (o_err_sof && sof_cyc < 0) sof_cyc = cyc;
        if (o_err_eol && eol_cyc < 0) eol_cyc = cyc;
        if (o_err_timeout && to_cyc < 0) to_cyc = cyc;
        if (o_done) done_seen = 1'b1;
    endtask

    task automatic src_update();
        if (i_axis_tvalid && i_axis_tready) begin
            if (frames_sent == 0 && src_idx == inj_sof) sof_inj_cyc = cyc;
            if (frames_sent == 0 && src_idx == inj_eol) eol_inj_cyc = cyc;
            src_idx++;
            if (src_idx == PIX) begin
                src_idx = 0;
                src_on  = 1'b0;
                frames_sent++;
            end
        end
        if (drop_frame > 0 && frames_sent == drop_frame - 1 && src_idx == 10) i_enable = 1'b0;
        if (src_arm) begin
            src_on  = 1'b1;
            src_arm = 1'b0;
        end
        if (o_gen_start) src_arm = 1'b1;
        tog = !tog;
        i_axis_tready = ready_mode ? tog : 1'b1;
        i_axis_tvalid = src_on && !src_stall;
        i_axis_tuser  = (src_idx == 0) ^ (frames_sent == 0 && src_idx == inj_sof);
        i_axis_tlast  = ((src_idx % W) == W - 1) ^ (frames_sent == 0 && src_idx == inj_eol);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        monitor();
        src_update();
    endtask

    task automatic src_reset();
        ready_mode = 1'b0; tog = 1'b0; src_on = 1'b0; src_arm = 1'b0; src_stall = 1'b0;
        src_idx = 0; frames_sent = 0; inj_sof = -1; inj_eol = -1; drop_frame = 0;
        sof_inj_cyc = -1; eol_inj_cyc = -1;
        i_axis_tvalid = 1'b0; i_axis_tready = 1'b0; i_axis_tuser = 1'b0; i_axis_tlast = 1'b0;
    endtask

    task automatic clear_mon();
        gs_cnt = 0; fd_cnt = 0; fd_last = -1; sof_cyc = -1; eol_cyc = -1; to_cyc = -1;
        gs_cyc[0] = -1; gs_cyc[1] = -1; done_seen = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        i_enable = 1'b0;
        src_reset();
        step();
        step();
        rst = 1'b0;
        step();
        clear_mon();
    endtask

    function automatic int all_outs();
        return int'({o_gen_start, o_busy, o_frame_done, o_frame_count, o_done,
                     o_err_sof, o_err_eol, o_err_timeout});
    endfunction

    task automatic run_row(input vec_t v, input int r);
        reset_dut();
        ready_mode   = v.rmode;
        inj_sof      = v.inj_sof;
        inj_eol      = v.inj_eol;
        drop_frame   = v.drop;
        i_num_frames = 16'(v.nf);
        i_enable     = 1'b1;
        for (int k = 0; k < 1500 && !done_seen; k++) step();
        check($sformatf("r%0d_done_seen", r), int'(done_seen), 1);
        check($sformatf("r%0d_done", r), int'(o_done), 1);
        check($sformatf("r%0d_busy", r), int'(o_busy), 0);
        check($sformatf("r%0d_frame_count", r), int'(o_frame_count), v.exp_frames);
        check($sformatf("r%0d_frame_done_pulses", r), fd_cnt, v.exp_frames);
        check($sformatf("r%0d_gen_start_pulses", r), gs_cnt, v.exp_frames);
        check($sformatf("r%0d_err_sof", r), int'(o_err_sof), int'(v.exp_sof));
        check($sformatf("r%0d_err_eol", r), int'(o_err_eol), int'(v.exp_eol));
        check($sformatf("r%0d_err_timeout", r), int'(o_err_timeout), 0);
        if (v.inj_sof >= 0) check($sformatf("r%0d_sof_timing", r), sof_cyc, sof_inj_cyc);
        if (v.inj_eol >= 0) check($sformatf("r%0d_eol_timing", r), eol_cyc, eol_inj_cyc);
        if (v.exp_spacing != 0)
            check($sformatf("r%0d_start_spacing", r),
                  (gs_cnt >= 2) ? gs_cyc[1] - gs_cyc[0] : -1, v.exp_spacing);
        i_enable = 1'b0;
        step();
        step();
        check($sformatf("r%0d_idle_done", r), int'(o_done), 0);
        check($sformatf("r%0d_idle_busy", r), int'(o_busy), 0);
    endtask

    vec_t tbl[7];

    initial begin
        // Start spacing with tready=1: START(1) + 32 beats + (GAP+1) = 37 cycles.
        tbl[0] = '{2, 1'b0, -1, -1, 0, 2, 1'b0, 1'b0, 37};
        tbl[1] = '{2, 1'b1, -1, -1, 0, 2, 1'b0, 1'b0, 0};
        tbl[2] = '{1, 1'b0, -1, 11, 0, 1, 1'b0, 1'b1, 0};  // tlast at col 3 row 1
        tbl[3] = '{1, 1'b1, -1,  7, 0, 1, 1'b0, 1'b1, 0};  // tlast missing at col 7
        tbl[4] = '{1, 1'b1,  5, -1, 0, 1, 1'b1, 1'b0, 0};  // stray tuser
        tbl[5] = '{1, 1'b0,  0, -1, 0, 1, 1'b1, 1'b0, 0};  // tuser missing at origin
        tbl[6] = '{0, 1'b0, -1, -1, 5, 5, 1'b0, 1'b0, 37}; // continuous, stop in frame 5

        src_reset();
        clear_mon();
        reset_dut();
        check("reset_outputs", all_outs(), 0);

        for (int r = 0; r < 7; r++) run_row(tbl[r], r);

        // Reset mid-RUN, then restart from a fresh enable edge.
        reset_dut();
        i_num_frames = 16'd1;
        i_enable = 1'b1;
        for (int k = 0; k < 200 && src_idx < 10; k++) step();
        check("rst_reached_run", int'(o_busy), 1);
        rst = 1'b1;
        i_enable = 1'b0;
        src_reset();
        step();
        check("rst_outputs", all_outs(), 0);
        rst = 1'b0;
        step();
        clear_mon();
        i_enable = 1'b1;
        step();
        step();
        check("restart_busy", int'(o_busy), 1);
        check("restart_count", int'(o_frame_count), 0);
        for (int k = 0; k < 500 && !done_seen; k++) step();
        check("restart_done", int'(o_done), 1);
        check("restart_count_end", int'(o_frame_count), 1);

        // Stalled stream in RUN.
        reset_dut();
        src_stall = 1'b1;
        i_num_frames = 16'd1;
        i_enable = 1'b1;
`ifdef FRAME_SCHEDULER_WATCHDOG_EN
        for (int k = 0; k < 300 && to_cyc < 0; k++) step();
        // RUN begins the cycle after gen_start; 20 idle RUN cycles, then the flag.
        check("wd_timing", (gs_cnt > 0 && to_cyc >= 0) ? to_cyc - gs_cyc[0] : -1, TO + 1);
        check("wd_err", int'(o_err_timeout), 1);
        check("wd_done", int'(o_done), 1);
        check("wd_busy", int'(o_busy), 0);
`else
        for (int k = 0; k < 100; k++) step();
        check("stall_err_timeout", int'(o_err_timeout), 0);
        check("stall_busy", int'(o_busy), 1);
        check("stall_done", int'(o_done), 0);
`endif
        reset_dut();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
